// File: rtl/decoder_nbit.sv
// rtl/decoder_nbit.sv - registered N-to-2^N one-hot decoder with DIRECT and SCAN modes (optional DECODER_ONEHOT_CHK_EN checker)
module decoder_nbit #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic               y_valid,
    output logic               scan_wrap
`ifdef DECODER_ONEHOT_CHK_EN
    ,
    output logic               err
`endif
);

    localparam int M = 2**N;
    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [M-1:0]       r_y;
    logic               r_y_valid;
    logic               r_in_ready;
    logic               r_scan_wrap;
    logic [N-1:0]       r_idx;
    logic [DWELL_W-1:0] r_count;
    logic               w_xfer;
    logic               w_step;
    logic [N-1:0]       w_idx_nxt;

    assign w_xfer    = in_valid & r_in_ready;
    assign w_step    = (r_count == dwell);
    assign w_idx_nxt = r_idx + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; en low wins over everything else
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next = mode ? S_SCAN : S_DIRECT;
                end
            end
            S_DIRECT: begin
                if (!en) begin
                    w_next = S_IDLE;
                end else if (mode) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!en) begin
                    w_next = S_IDLE;
                end else if (!mode) begin
                    w_next = S_DIRECT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs, scan index and dwell counter, all keyed off the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_scan_wrap <= 1'b0;
            r_idx       <= '0;
            r_count     <= '0;
        end else begin
            r_in_ready  <= (w_next == S_DIRECT);
            r_scan_wrap <= 1'b0;
            case (w_next)
                S_DIRECT: begin
                    if (r_state != S_DIRECT) begin
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                    end else if (w_xfer) begin
                        r_y       <= ONE << in_sel;
                        r_y_valid <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_state != S_SCAN) begin
                        r_idx     <= '0;
                        r_count   <= '0;
                        r_y       <= ONE;
                        r_y_valid <= 1'b1;
                    end else if (w_step) begin
                        r_count     <= '0;
                        r_idx       <= w_idx_nxt;
                        r_y         <= ONE << w_idx_nxt;
                        r_scan_wrap <= (w_idx_nxt == '0);
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign in_ready  = r_in_ready;
    assign scan_wrap = r_scan_wrap;

`ifdef DECODER_ONEHOT_CHK_EN
    logic r_err;
    logic w_multi;
    logic w_valid_zero;

    assign w_multi      = |(r_y & (r_y - ONE));
    assign w_valid_zero = r_y_valid & ~(|r_y);

    // Sticky flag for a multi-hot output or a valid output with no line set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_multi | w_valid_zero;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_decoder_nbit.sv
// tb/tb_decoder_nbit.sv - randomized self-checking bench for decoder_nbit
module tb_decoder_nbit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode, in_valid, in_ready;
    logic [2:0]  in_sel;
    logic [7:0]  dwell;
    logic [7:0]  y;
    logic        y_valid, scan_wrap;

    logic        en4, mode4, in_valid4, in_ready4;
    logic [3:0]  in_sel4;
    logic [7:0]  dwell4;
    logic [15:0] y4;
    logic        y_valid4, scan_wrap4;
`ifdef DECODER_ONEHOT_CHK_EN
    logic        err, err4;
`endif

    int vectors = 0;
    int miscompares = 0;

    decoder_nbit #(.N(3), .DWELL_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .dwell(dwell),
        .y(y), .y_valid(y_valid), .scan_wrap(scan_wrap)
`ifdef DECODER_ONEHOT_CHK_EN
        , .err(err)
`endif
    );

    decoder_nbit #(.N(4), .DWELL_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_sel(in_sel4), .dwell(dwell4),
        .y(y4), .y_valid(y_valid4), .scan_wrap(scan_wrap4)
`ifdef DECODER_ONEHOT_CHK_EN
        , .err(err4)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; mode = 0; in_valid = 0; in_sel = 0; dwell = 0;
        en4 = 0; mode4 = 0; in_valid4 = 0; in_sel4 = 0; dwell4 = 0;
        tick(); tick();
        vectors++;
        if ({y, y_valid, in_ready, scan_wrap} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got y=%h yv=%b rdy=%b wrap=%b, want all 0", y, y_valid, in_ready, scan_wrap);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({y, y_valid, in_ready} !== 10'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got y=%h yv=%b rdy=%b, want 0", y, y_valid, in_ready);
        end
    endtask

    task automatic test_direct();
        logic [7:0] exp_y;
        logic       exp_v;
        en = 1; mode = 0; in_valid = 0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || y_valid !== 1'b0 || y !== 8'h00) begin
            miscompares++;
            $display("FAIL direct_entry: got rdy=%b yv=%b y=%h, want rdy=1 yv=0 y=00", in_ready, y_valid, y);
        end
        in_sel = 3'd5; in_valid = 1;
        tick();
        in_valid = 0;
        vectors++;
        if (y !== 8'h20 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_sel5: got y=%h yv=%b, want 20 1", y, y_valid);
        end
        exp_y = 8'h20; exp_v = 1;
        for (int i = 0; i < 3; i++) begin
            in_sel = 3'($urandom_range(0, 7));
            tick();
            vectors++;
            if (y !== exp_y || y_valid !== exp_v) begin
                miscompares++;
                $display("FAIL direct_hold: got y=%h yv=%b, want %h %b", y, y_valid, exp_y, exp_v);
            end
        end
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 3'($urandom_range(0, 7));
            if (in_valid) begin
                exp_y = 8'd1 << in_sel;
                exp_v = 1;
            end
            tick();
            vectors++;
            if (y !== exp_y || y_valid !== exp_v || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL direct_random: got y=%h yv=%b rdy=%b, want %h %b 1", y, y_valid, in_ready, exp_y, exp_v);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_scan(input int d);
        int ei;
        logic ew;
        en = 1; mode = 0; in_valid = 0;
        tick();
        dwell = 8'(d); mode = 1;
        tick();
        vectors++;
        if (y !== 8'h01 || y_valid !== 1'b1 || scan_wrap !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_entry d=%0d: got y=%h yv=%b wrap=%b rdy=%b, want 01 1 0 0", d, y, y_valid, scan_wrap, in_ready);
        end
        for (int k = 1; k <= 8 * (d + 1) + 2; k++) begin
            tick();
            ei = (k / (d + 1)) % 8;
            ew = ((k % (d + 1)) == 0) && (ei == 0);
            vectors++;
            if (y !== (8'd1 << ei) || scan_wrap !== ew || y_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL scan_walk d=%0d k=%0d: got y=%h wrap=%b yv=%b, want %h %b 1", d, k, y, scan_wrap, y_valid, 8'd1 << ei, ew);
            end
        end
    endtask

    task automatic test_dwell_change();
        en = 1; mode = 0; tick();
        dwell = 0; mode = 1; tick();
        tick(); tick(); tick();
        dwell = 1;
        tick();
        vectors++;
        if (y !== 8'h08) begin
            miscompares++;
            $display("FAIL dwell_change_hold: got y=%h, want 08", y);
        end
        tick();
        vectors++;
        if (y !== 8'h10) begin
            miscompares++;
            $display("FAIL dwell_change_step: got y=%h, want 10", y);
        end
    endtask

    task automatic test_mode_switch();
        en = 1; mode = 0; tick();
        dwell = 0; mode = 1; tick();
        tick(); tick(); tick();
        vectors++;
        if (y !== 8'h08) begin
            miscompares++;
            $display("FAIL switch_pre: got y=%h, want 08", y);
        end
        mode = 0;
        tick();
        vectors++;
        if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b1 || scan_wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_to_direct: got y=%h yv=%b rdy=%b wrap=%b, want 00 0 1 0", y, y_valid, in_ready, scan_wrap);
        end
        in_sel = 3'd7; in_valid = 1;
        tick();
        vectors++;
        if (y !== 8'h80 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL switch_sel7: got y=%h yv=%b, want 80 1", y, y_valid);
        end
        in_sel = 3'd3; in_valid = 1; mode = 1;
        tick();
        in_valid = 0;
        vectors++;
        if (y !== 8'h01 || y_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL xfer_with_mode: got y=%h yv=%b rdy=%b, want 01 1 0", y, y_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        en = 1; mode = 0; tick();
        dwell = 1; mode = 1; tick(); tick(); tick();
        #3;
        rst_n = 0;
        #1;
        vectors++;
        if ({y, y_valid, in_ready, scan_wrap} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: got y=%h yv=%b rdy=%b wrap=%b, want all 0", y, y_valid, in_ready, scan_wrap);
        end
        en = 0;
        #2;
        rst_n = 1;
        tick();
        vectors++;
        if (y !== 8'h00 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got y=%h yv=%b, want 00 0", y, y_valid);
        end
        en = 1; mode = 1; tick();
        vectors++;
        if (y !== 8'h01 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reentry_scan: got y=%h yv=%b, want 01 1", y, y_valid);
        end
        en = 0; in_valid = 1; tick();
        in_valid = 0;
        vectors++;
        if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low: got y=%h yv=%b rdy=%b, want 00 0 0", y, y_valid, in_ready);
        end
    endtask

    task automatic test_n4();
        en4 = 1; mode4 = 0; tick();
        in_sel4 = 4'd15; in_valid4 = 1; tick();
        in_valid4 = 0;
        vectors++;
        if (y4 !== 16'h8000 || y_valid4 !== 1'b1) begin
            miscompares++;
            $display("FAIL n4_sel15: got y=%h yv=%b, want 8000 1", y4, y_valid4);
        end
        dwell4 = 0; mode4 = 1; tick();
        for (int k = 0; k <= 16; k++) begin
            vectors++;
            if (y4 !== (16'd1 << (k % 16)) || scan_wrap4 !== (k == 16)) begin
                miscompares++;
                $display("FAIL n4_scan k=%0d: got y=%h wrap=%b, want %h %b", k, y4, scan_wrap4, 16'd1 << (k % 16), k == 16);
            end
            tick();
        end
`ifdef DECODER_ONEHOT_CHK_EN
        vectors++;
        if (err4 !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_flag: got err4=%b err=%b, want 0 0", err4, err);
        end
`endif
        en4 = 0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan(2);
        test_scan(0);
        test_scan($urandom_range(1, 5));
        test_dwell_change();
        test_mode_switch();
        test_async_reset();
        test_n4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
